axi_sram_slave: RTL

//  AXI4 slave endpoint behind the interconnect's S0/S1 ports; turns AXI read/write bursts into

---
 rtl/axi_sram_pkg.sv | 47 ++++
 rtl/axi_sram_burst_addr.sv | 22 ++
 rtl/axi_sram_slave.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_pkg.sv
// Shared types and constants for the AXI4-to-SRAM slave.
// Optional out-of-range error responses are enabled by defining AXI_SRAM_SLVERR_EN.
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 8
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

package axi_sram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_DATA,
    WR_DATA,
    WR_RESP
  } state_t;

  typedef enum logic {
    PRIO_RD,
    PRIO_WR
  } prio_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [1:0] resp_for(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_sram_burst_addr.sv
// Next SRAM word address for a burst beat: FIXED holds, everything else increments
// modulo 2^MEM_AW (WRAP and the reserved encoding behave as INCR).
module axi_sram_burst_addr
  import axi_sram_pkg::*;
#(
  parameter int unsigned MEM_AW = 14
) (
  input  logic [MEM_AW-1:0] cur_addr,
  input  logic [1:0]        burst,
  output logic [MEM_AW-1:0] next_addr
);

  always_comb begin
    next_addr = cur_addr + MEM_AW'(1);
    case (burst)
      BURST_FIXED:            next_addr = cur_addr;
      BURST_INCR, BURST_WRAP: next_addr = cur_addr + MEM_AW'(1);
      default:                next_addr = cur_addr + MEM_AW'(1);
    endcase
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave turning single-outstanding INCR/FIXED bursts into 1-cycle-latency SRAM accesses.
// Define AXI_SRAM_SLVERR_EN to answer out-of-range bursts with SLVERR instead of aliasing.
module axi_sram_slave
  import axi_sram_pkg::*;
#(
  parameter int unsigned MEM_AW = 14
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [`AXI_IDS_BITS-1:0]   AWID,
  input  logic [`AXI_ADDR_BITS-1:0]  AWADDR,
  input  logic [`AXI_LEN_BITS-1:0]   AWLEN,
  input  logic [`AXI_SIZE_BITS-1:0]  AWSIZE,
  input  logic [1:0]                 AWBURST,
  input  logic                       AWVALID,
  output logic                       AWREADY,
  input  logic [`AXI_DATA_BITS-1:0]  WDATA,
  input  logic [`AXI_STRB_BITS-1:0]  WSTRB,
  input  logic                       WLAST,
  input  logic                       WVALID,
  output logic                       WREADY,
  output logic [`AXI_IDS_BITS-1:0]   BID,
  output logic [1:0]                 BRESP,
  output logic                       BVALID,
  input  logic                       BREADY,
  input  logic [`AXI_IDS_BITS-1:0]   ARID,
  input  logic [`AXI_ADDR_BITS-1:0]  ARADDR,
  input  logic [`AXI_LEN_BITS-1:0]   ARLEN,
  input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE,
  input  logic [1:0]                 ARBURST,
  input  logic                       ARVALID,
  output logic                       ARREADY,
  output logic [`AXI_IDS_BITS-1:0]   RID,
  output logic [`AXI_DATA_BITS-1:0]  RDATA,
  output logic [1:0]                 RRESP,
  output logic                       RLAST,
  output logic                       RVALID,
  input  logic                       RREADY,
  output logic                       sram_cs,
  output logic                       sram_we,
  output logic [MEM_AW-1:0]          sram_addr,
  output logic [`AXI_STRB_BITS-1:0]  sram_wstrb,
  output logic [`AXI_DATA_BITS-1:0]  sram_wdata,
  input  logic [`AXI_DATA_BITS-1:0]  sram_rdata
);

  state_t                    state, state_nxt;
  prio_t                     prio;
  logic [`AXI_IDS_BITS-1:0]  id_q;
  logic [`AXI_LEN_BITS-1:0]  len_q, cnt_q;
  logic [1:0]                burst_q;
  logic [MEM_AW-1:0]         addr_q, addr_nxt;
  logic                      err_q;
  logic                      ar_hs, aw_hs, r_hs, w_hs, last_beat;
  logic                      ar_err, aw_err;
  logic                      unused_ok;

`ifdef AXI_SRAM_SLVERR_EN
  assign ar_err    = |ARADDR[`AXI_ADDR_BITS-1:MEM_AW+2];
  assign aw_err    = |AWADDR[`AXI_ADDR_BITS-1:MEM_AW+2];
  assign unused_ok = ^{AWSIZE, ARSIZE, WLAST, AWADDR[1:0], ARADDR[1:0]};
`else
  assign ar_err    = 1'b0;
  assign aw_err    = 1'b0;
  assign unused_ok = ^{AWSIZE, ARSIZE, WLAST, AWADDR[1:0], ARADDR[1:0],
                       AWADDR[`AXI_ADDR_BITS-1:MEM_AW+2], ARADDR[`AXI_ADDR_BITS-1:MEM_AW+2]};
`endif

  axi_sram_burst_addr #(.MEM_AW(MEM_AW)) u_burst_addr (
    .cur_addr  (addr_q),
    .burst     (burst_q),
    .next_addr (addr_nxt)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state   <= IDLE;
      prio    <= PRIO_RD;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (ar_hs) begin
        id_q    <= ARID;
        len_q   <= ARLEN;
        burst_q <= ARBURST;
        addr_q  <= ARADDR[MEM_AW+1:2];
        cnt_q   <= '0;
        err_q   <= ar_err;
      end else if (aw_hs) begin
        id_q    <= AWID;
        len_q   <= AWLEN;
        burst_q <= AWBURST;
        addr_q  <= AWADDR[MEM_AW+1:2];
        cnt_q   <= '0;
        err_q   <= aw_err;
      end
      // priority only moves when both channels competed for the same slot
      if ((ar_hs || aw_hs) && ARVALID && AWVALID)
        prio <= ar_hs ? PRIO_WR : PRIO_RD;
      if (r_hs || w_hs) begin
        addr_q <= addr_nxt;
        cnt_q  <= cnt_q + `AXI_LEN_BITS'(1);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    AWREADY    = 1'b0;
    WREADY     = 1'b0;
    BID        = '0;
    BRESP      = '0;
    BVALID     = 1'b0;
    ARREADY    = 1'b0;
    RID        = '0;
    RDATA      = '0;
    RRESP      = '0;
    RLAST      = 1'b0;
    RVALID     = 1'b0;
    sram_cs    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wstrb = '0;
    sram_wdata = '0;
    ar_hs      = 1'b0;
    aw_hs      = 1'b0;
    r_hs       = 1'b0;
    w_hs       = 1'b0;
    last_beat  = (cnt_q == len_q);
    if (!ARESET) begin
      case (state)
        IDLE: begin
          ARREADY = ARVALID && (!AWVALID || prio == PRIO_RD);
          AWREADY = AWVALID && (!ARVALID || prio == PRIO_WR);
          ar_hs   = ARREADY;
          aw_hs   = AWREADY;
          if (ar_hs) begin
            // first beat is fetched in the address cycle so RVALID can rise next cycle
            sram_cs   = !ar_err;
            sram_addr = ARADDR[MEM_AW+1:2];
            state_nxt = RD_DATA;
          end else if (aw_hs) begin
            state_nxt = WR_DATA;
          end
        end
        RD_DATA: begin
          RVALID = 1'b1;
          RID    = id_q;
          RDATA  = err_q ? '0 : sram_rdata;
          RRESP  = resp_for(err_q);
          RLAST  = last_beat;
          r_hs   = RREADY;
          if (r_hs) begin
            if (last_beat) begin
              state_nxt = IDLE;
            end else begin
              sram_cs   = !err_q;
              sram_addr = addr_nxt;
            end
          end
        end
        WR_DATA: begin
          WREADY = 1'b1;
          w_hs   = WVALID;
          if (w_hs) begin
            if (!err_q) begin
              sram_cs    = 1'b1;
              sram_we    = 1'b1;
              sram_addr  = addr_q;
              sram_wstrb = WSTRB;
              sram_wdata = WDATA;
            end
            if (last_beat)
              state_nxt = WR_RESP;
          end
        end
        WR_RESP: begin
          BVALID = 1'b1;
          BID    = id_q;
          BRESP  = resp_for(err_q);
          if (BREADY)
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
